rc4_key_search: RTL and testbench

- Supervises the RC4 decrypt pipeline (S-init, KSA, PRGA) and sits directly downstream of it: it consumes the decrypted-byte write stream the PRGA produces into D memory.
- Launches one decrypt round per candidate key and checks every decrypted byte as it is written.
- Aborts a round at the first byte outside the accepted character set, then advances the key.
- Stops with found or failed status, presenting the winning key to the top level for LED/HEX display.

---
 rtl/rc4_key_search.sv | 130 +++++++++++++
 tb/tb_rc4_key_search.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search.sv
// RC4 key-search supervisor: launches one decrypt round per candidate key and checks the PRGA output stream.
// Optional macro RC4_KEY_SEARCH_PUNCT_EN adds , . ' ! ? to the accepted character set.
module rc4_key_search #(
    parameter int                   KEY_WIDTH = 22,
    parameter int                   MSG_LEN   = 32,
    parameter logic [KEY_WIDTH-1:0] KEY_LO    = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_HI    = {KEY_WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dec_wren,
    input  logic [7:0]           dec_addr,
    input  logic [7:0]           dec_data,
    input  logic                 round_done,
    output logic                 round_start,
    output logic                 round_abort,
    output logic [23:0]          secret_key,
    output logic                 busy,
    output logic                 found,
    output logic                 failed,
    output logic [KEY_WIDTH:0]   attempts
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_ABORT, S_NEXT, S_FOUND, S_FAIL
    } state_t;

    localparam logic [8:0] ADDR_LIM  = 9'(MSG_LEN);
    localparam logic [5:0] MSG_CNT   = 6'(MSG_LEN);
    localparam logic [2:0] DRAIN_END = 3'd4;

    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [KEY_WIDTH:0]   att_q, att_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 bad_q, bad_d;
    logic [2:0]           drain_q, drain_d;
    logic                 wr_valid, byte_bad;

    function automatic logic char_ok(input logic [7:0] c);
        logic ok;
        ok = (c >= 8'h61 && c <= 8'h7A) || c == 8'h20;
`ifdef RC4_KEY_SEARCH_PUNCT_EN
        ok = ok || (c inside {8'h2C, 8'h2E, 8'h27, 8'h21, 8'h3F});
`endif
        return ok;
    endfunction

    assign wr_valid = dec_wren && ({1'b0, dec_addr} < ADDR_LIM);
    assign byte_bad = wr_valid && !char_ok(dec_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            key_q   <= KEY_LO;
            att_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            att_q   <= att_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        att_d   = att_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE, S_FOUND, S_FAIL: begin
                if (start) begin
                    key_d   = KEY_LO;
                    att_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                att_d   = att_q + 1'b1;
                cnt_d   = '0;
                bad_d   = 1'b0;
                drain_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (wr_valid) begin
                    if (cnt_q != 6'h3F) cnt_d = cnt_q + 1'b1;
                    if (byte_bad) bad_d = 1'b1;
                end
                // A bad byte coinciding with round_done only latches bad; the
                // bad_q check on the following cycle then routes to ABORT.
                if (bad_q)
                    state_d = S_ABORT;
                else if (round_done && !byte_bad)
                    state_d = (cnt_d == MSG_CNT) ? S_FOUND : S_NEXT;
            end
            S_ABORT: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DRAIN_END) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (key_q == KEY_HI) begin
                    state_d = S_FAIL;
                end else begin
                    key_d   = key_q + 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign round_start = (state_q == S_LAUNCH);
    assign round_abort = (state_q == S_ABORT) && (drain_q == '0);
    assign busy        = (state_q == S_LAUNCH) || (state_q == S_RUN) ||
                         (state_q == S_ABORT)  || (state_q == S_NEXT);
    assign found       = (state_q == S_FOUND);
    assign failed      = (state_q == S_FAIL);
    assign secret_key  = 24'(key_q);
    assign attempts    = att_q;

endmodule

// File: tb/tb_rc4_key_search.sv
// Directed bench for rc4_key_search: a small PRGA write-stream model drives rounds and checks search status.
module tb_rc4_key_search;

    logic        clk = 1'b0;
    logic        reset, start, start2, dec_wren, round_done;
    logic [7:0]  dec_addr, dec_data;
    logic        rs1, ra1, busy1, found1, failed1;
    logic        rs2, ra2, busy2, found2, failed2;
    logic [23:0] sk1, sk2;
    logic [22:0] att1, att2;

    int errors = 0;
    int checks = 0;
    int abort_cnt = 0;
    string msg = "the quick brown fox jumps over l";

`ifdef RC4_KEY_SEARCH_PUNCT_EN
    localparam bit PUNCT = 1'b1;
`else
    localparam bit PUNCT = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         ok;
    } vec_t;
    vec_t tbl[14];

    always #5 clk = ~clk;

    rc4_key_search dut1 (
        .clk(clk), .reset(reset), .start(start), .dec_wren(dec_wren),
        .dec_addr(dec_addr), .dec_data(dec_data), .round_done(round_done),
        .round_start(rs1), .round_abort(ra1), .secret_key(sk1), .busy(busy1),
        .found(found1), .failed(failed1), .attempts(att1)
    );

    rc4_key_search #(.KEY_LO(22'h3FFFFE), .KEY_HI(22'h3FFFFF)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .dec_wren(dec_wren),
        .dec_addr(dec_addr), .dec_data(dec_data), .round_done(round_done),
        .round_start(rs2), .round_abort(ra2), .secret_key(sk2), .busy(busy2),
        .found(found2), .failed(failed2), .attempts(att2)
    );

    always @(posedge clk) if (ra1) abort_cnt <= abort_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit which);
        if (which) start2 = 1'b1; else start = 1'b1;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits (bounded) for round_start, then steps into the RUN cycle.
    task automatic launch(input bit which, input string nm, input logic [23:0] exp_key);
        int n = 0;
        while (!(which ? rs2 : rs1) && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else chk({nm, "_key"}, which ? sk2 : sk1, exp_key);
        tick();
    endtask

    task automatic send(input int n, input int bad_pos, input logic [7:0] bad_byte, input bit done);
        for (int i = 0; i < n; i++) begin
            dec_wren   = 1'b1;
            dec_addr   = 8'(i);
            dec_data   = (i == bad_pos) ? bad_byte : 8'(msg[i]);
            round_done = done && (i == n - 1);
            tick();
        end
        dec_wren   = 1'b0;
        round_done = 1'b0;
        dec_addr   = '0;
        dec_data   = '0;
    endtask

    initial begin
        int base;
        tbl[0]  = '{8'h61, 1'b1};
        tbl[1]  = '{8'h7A, 1'b1};
        tbl[2]  = '{8'h20, 1'b1};
        tbl[3]  = '{8'h60, 1'b0};
        tbl[4]  = '{8'h7B, 1'b0};
        tbl[5]  = '{8'h41, 1'b0};
        tbl[6]  = '{8'h00, 1'b0};
        tbl[7]  = '{8'h1F, 1'b0};
        tbl[8]  = '{8'h2C, PUNCT};
        tbl[9]  = '{8'h2E, PUNCT};
        tbl[10] = '{8'h27, PUNCT};
        tbl[11] = '{8'h21, PUNCT};
        tbl[12] = '{8'h3F, PUNCT};
        tbl[13] = '{8'hFF, 1'b0};

        reset = 1'b1; start = 0; start2 = 0; dec_wren = 0; round_done = 0;
        dec_addr = '0; dec_data = '0;
        tick(); tick();
        chk("rst_busy", busy1, 0);
        chk("rst_found", found1, 0);
        chk("rst_failed", failed1, 0);
        chk("rst_attempts", att1, 0);
        chk("rst_rstart", rs1, 0);
        chk("rst_key", sk1, 24'h000000);
        chk("rst_key2", sk2, 24'h3FFFFE);
        reset = 1'b0;
        tick();

        // Valid round with key 0
        pulse_start(0);
        launch(0, "valid", 24'h0);
        send(32, -1, 8'h00, 1);
        chk("valid_found", found1, 1);
        chk("valid_key", sk1, 24'h0);
        chk("valid_att", att1, 1);
        chk("valid_busy", busy1, 0);

        // First-byte abort, then key 1 passes
        pulse_start(0);
        launch(0, "fb", 24'h0);
        chk("fb_found_cleared", found1, 0);
        dec_wren = 1'b1; dec_addr = 8'h00; dec_data = 8'h41;
        tick();
        dec_wren = 1'b0;
        chk("fb_abort_early", ra1, 0);
        tick();
        chk("fb_abort", ra1, 1);
        launch(0, "fb_r2", 24'h1);
        chk("fb_att", att1, 2);
        send(32, -1, 8'h00, 1);
        chk("fb_found", found1, 1);

        // Search to hit at key 3
        pulse_start(0);
        for (int k = 0; k < 4; k++) begin
            launch(0, "hit", 24'(k));
            if (k < 3) send(6, 5, 8'h7B, 0);
            else send(32, -1, 8'h00, 1);
        end
        chk("hit_found", found1, 1);
        chk("hit_key", sk1, 24'h3);
        chk("hit_att", att1, 4);
        chk("hit_busy", busy1, 0);

        // Invalid byte together with round_done -> ABORT
        pulse_start(0);
        launch(0, "sim", 24'h0);
        send(32, 31, 8'h41, 1);
        chk("sim_found", found1, 0);
        tick();
        chk("sim_abort", ra1, 1);
        // Only 31 bytes before round_done -> NEXT
        launch(0, "short", 24'h1);
        send(31, -1, 8'h00, 1);
        chk("short_found", found1, 0);
        chk("short_busy", busy1, 1);
        // Out-of-range address is neither counted nor checked
        launch(0, "oor", 24'h2);
        dec_wren = 1'b1; dec_addr = 8'h20; dec_data = 8'h00;
        tick();
        dec_wren = 1'b0;
        send(32, -1, 8'h00, 1);
        chk("oor_found", found1, 1);
        chk("oor_key", sk1, 24'h2);
        chk("oor_att", att1, 3);

        // Asynchronous reset mid-round
        pulse_start(0);
        launch(0, "mrst", 24'h0);
        send(5, -1, 8'h00, 0);
        #2 reset = 1'b1;
        #1;
        chk("mrst_busy", busy1, 0);
        chk("mrst_att", att1, 0);
        chk("mrst_found", found1, 0);
        chk("mrst_key", sk1, 24'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        pulse_start(0);
        launch(0, "mrst_r", 24'h0);
        chk("mrst_att1", att1, 1);
        send(32, -1, 8'h00, 1);
        chk("mrst_found2", found1, 1);

        // Character-set table: byte under test at position 7
        for (int v = 0; v < 14; v++) begin
            do_reset();
            base = abort_cnt;
            pulse_start(0);
            launch(0, $sformatf("tbl%0d", v), 24'h0);
            send(32, 7, tbl[v].data, 1);
            chk($sformatf("tbl_found_%02h", tbl[v].data), found1, 32'(tbl[v].ok));
            chk($sformatf("tbl_abort_%02h", tbl[v].data), 32'(abort_cnt != base), 32'(!tbl[v].ok));
        end

        // Punctuation build option: '.' inside the message
        do_reset();
        pulse_start(0);
        launch(0, "punct", 24'h0);
        send(32, 3, 8'h2E, 1);
        chk("punct_found", found1, 32'(PUNCT));

        // Exhaustion on a two-key range
        do_reset();
        pulse_start(1);
        for (int r = 0; r < 2; r++) begin
            launch(1, "exh", 24'h3FFFFE + 24'(r));
            send(1, 0, 8'h41, 0);
        end
        begin
            int n = 0;
            while (!failed2 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("exh_failed", failed2, 1);
        chk("exh_key", sk2, 24'h3FFFFF);
        chk("exh_found", found2, 0);
        chk("exh_att", att2, 2);
        chk("exh_busy", busy2, 0);
        pulse_start(1);
        chk("exh_restart_failed", failed2, 0);
        chk("exh_restart_busy", busy2, 1);
        chk("exh_restart_key", sk2, 24'h3FFFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
